// File: rtl/rat_intc_pkg.sv
// Shared types and limits for the RAT interrupt controller.
package rat_intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_t;

  localparam int MAX_SRC = 8;

endpackage

// File: rtl/intr_edge_sync.sv
// Per-line synchroniser followed by a rising-edge detector; pulse_o is high
// for one cycle when the synchronised line goes 0 -> 1.
module intr_edge_sync
  import rat_intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_controller.sv
// Multi-source interrupt scheduler: latches edge events as pending, masks and
// fixed-priority arbitrates them, and hands one request at a time to the CPU.
module intr_controller
  import rat_intc_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = $clog2(NUM_SRC),
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] INT_SRC,
  input  logic               I_EN,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_IN,
  input  logic               INT_ACK,
  input  logic               RETI,
  output logic               INTR,
  output logic [ID_W-1:0]    INT_ID,
  output logic               IN_SERVICE,
  output logic [NUM_SRC-1:0] PENDING,
  output logic [NUM_SRC-1:0] MASK
);

  // lowest set index wins
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      r = v[i] ? ID_W'(i) : r;
    end
    return r;
  endfunction

  logic [NUM_SRC-1:0] edge_s, eligible_s, sel_s, clr_s;
  logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d;
  logic [ID_W-1:0]    int_id_q, int_id_d, winner_s;
  logic               intr_q, intr_d, in_service_q, in_service_d;
  logic               ack_s, cur_en_s;
  intc_state_t        state_q, state_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .RESET_N (RESET_N),
      .async_i (INT_SRC[g]),
      .pulse_o (edge_s[g])
    );
  end

  assign eligible_s = pending_q & mask_q;
  assign winner_s   = prio_enc(eligible_s);
  assign ack_s      = (state_q == ST_REQ) && INT_ACK;

  // one-hot select of the current ID and whether that source is still unmasked
  always_comb begin
    sel_s    = '0;
    cur_en_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ID_W'(i) == int_id_q) begin
        sel_s[i] = 1'b1;
        cur_en_s = mask_q[i];
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // new edges win over the acknowledge clear so a coincident event survives
  assign clr_s     = ack_s ? sel_s : '0;
  assign pending_d = (pending_q & ~clr_s) | edge_s;
  assign mask_d    = MASK_WE ? MASK_IN : mask_q;

  // FSM next state and registered request outputs
  always_comb begin
    state_d      = state_q;
    int_id_d     = int_id_q;
    intr_d       = intr_q;
    in_service_d = in_service_q;
    case (state_q)
      ST_IDLE: begin
        if (I_EN && |eligible_s) begin
          int_id_d = winner_s;
          intr_d   = 1'b1;
          state_d  = ST_REQ;
        end else begin
          intr_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (INT_ACK) begin
          intr_d       = 1'b0;
          in_service_d = 1'b1;
          state_d      = ST_SERVICE;
        end else if (!I_EN || !cur_en_s) begin
          intr_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          intr_d = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (RETI) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          in_service_d = 1'b1;
        end
      end
      default: begin
        intr_d       = 1'b0;
        in_service_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      int_id_q     <= '0;
      intr_q       <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_id_q     <= int_id_d;
      intr_q       <= intr_d;
      in_service_q <= in_service_d;
    end
  end

  assign INTR       = intr_q;
  assign INT_ID     = int_id_q;
  assign IN_SERVICE = in_service_q;
  assign PENDING    = pending_q;
  assign MASK       = mask_q;

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: hand-computed expectations for each step.
module tb_intr_controller;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic [3:0] INT_SRC, MASK_IN;
  logic       I_EN, MASK_WE, INT_ACK, RETI;
  logic       INTR, IN_SERVICE;
  logic [1:0] INT_ID;
  logic [3:0] PENDING, MASK;

  int checks = 0;
  int errors = 0;

  intr_controller #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .INT_SRC    (INT_SRC),
    .I_EN       (I_EN),
    .MASK_WE    (MASK_WE),
    .MASK_IN    (MASK_IN),
    .INT_ACK    (INT_ACK),
    .RETI       (RETI),
    .INTR       (INTR),
    .INT_ID     (INT_ID),
    .IN_SERVICE (IN_SERVICE),
    .PENDING    (PENDING),
    .MASK       (MASK)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // raise lines, wait for pending to latch (3 cycles), drop lines
  task automatic raise_src(input logic [3:0] v);
    INT_SRC = v;
    tick(3);
    INT_SRC = 4'b0000;
  endtask

  initial begin
    RESET_N = 1'b0; INT_SRC = 4'b0000; MASK_IN = 4'b0000; I_EN = 1'b0;
    MASK_WE = 1'b0; INT_ACK = 1'b0; RETI = 1'b0;
    tick(2);
    chk("rst_intr", {3'b000, INTR}, 4'h0);
    chk("rst_id", {2'b00, INT_ID}, 4'h0);
    chk("rst_insvc", {3'b000, IN_SERVICE}, 4'h0);
    chk("rst_pend", PENDING, 4'h0);
    chk("rst_mask", MASK, 4'h0);
    RESET_N = 1'b1;
    tick(1);

    MASK_WE = 1'b1; MASK_IN = 4'b1111; I_EN = 1'b1;
    tick(1);
    MASK_WE = 1'b0;
    chk("mask_wr", MASK, 4'b1111);

    // single source 2: latency, request, ack, return
    INT_SRC = 4'b0100;
    tick(1); chk("lat_c1_pend", PENDING, 4'b0000);
    tick(1); chk("lat_c2_pend", PENDING, 4'b0000);
    tick(1); chk("lat_c3_pend", PENDING, 4'b0100);
    chk("lat_c3_intr", {3'b000, INTR}, 4'h0);
    INT_SRC = 4'b0000;
    tick(1);
    chk("s2_intr", {3'b000, INTR}, 4'h1);
    chk("s2_id", {2'b00, INT_ID}, 4'h2);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    chk("s2_ack_pend", PENDING, 4'b0000);
    chk("s2_ack_insvc", {3'b000, IN_SERVICE}, 4'h1);
    chk("s2_ack_intr", {3'b000, INTR}, 4'h0);
    chk("s2_svc_id", {2'b00, INT_ID}, 4'h2);
    RETI = 1'b1; tick(1); RETI = 1'b0;
    chk("s2_reti_insvc", {3'b000, IN_SERVICE}, 4'h0);
    tick(1);
    chk("s2_idle_intr", {3'b000, INTR}, 4'h0);

    // simultaneous sources 3 and 1
    raise_src(4'b1010);
    chk("dual_pend", PENDING, 4'b1010);
    tick(1);
    chk("dual_first_intr", {3'b000, INTR}, 4'h1);
    chk("dual_first_id", {2'b00, INT_ID}, 4'h1);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    chk("dual_ack_pend", PENDING, 4'b1000);
    tick(2);
    chk("dual_no_nest", {3'b000, INTR}, 4'h0);
    RETI = 1'b1; tick(1); RETI = 1'b0;
    chk("dual_reti_intr", {3'b000, INTR}, 4'h0);
    tick(1);
    chk("dual_second_intr", {3'b000, INTR}, 4'h1);
    chk("dual_second_id", {2'b00, INT_ID}, 4'h3);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    chk("dual_empty", PENDING, 4'b0000);
    RETI = 1'b1; tick(1); RETI = 1'b0;

    // masked source 0, then unmask
    MASK_WE = 1'b1; MASK_IN = 4'b1110; tick(1); MASK_WE = 1'b0;
    raise_src(4'b0001);
    chk("mask_pend", PENDING, 4'b0001);
    tick(1);
    chk("mask_blocked", {3'b000, INTR}, 4'h0);
    MASK_WE = 1'b1; MASK_IN = 4'b1111; tick(1); MASK_WE = 1'b0;
    chk("unmask_c1", {3'b000, INTR}, 4'h0);
    tick(1);
    chk("unmask_c2_intr", {3'b000, INTR}, 4'h1);
    chk("unmask_c2_id", {2'b00, INT_ID}, 4'h0);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    RETI = 1'b1; tick(1); RETI = 1'b0;

    // withdrawal on I_EN drop, re-request on I_EN rise
    raise_src(4'b0100);
    tick(1);
    chk("wd_req_id", {2'b00, INT_ID}, 4'h2);
    I_EN = 1'b0; tick(1);
    chk("wd_intr", {3'b000, INTR}, 4'h0);
    chk("wd_pend", PENDING, 4'b0100);
    tick(1);
    chk("wd_hold", {3'b000, INTR}, 4'h0);
    I_EN = 1'b1; tick(1);
    chk("wd_rereq_intr", {3'b000, INTR}, 4'h1);
    chk("wd_rereq_id", {2'b00, INT_ID}, 4'h2);

    // new edge on source 2 lands in its own ack cycle
    INT_SRC = 4'b0100;
    tick(2);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    INT_SRC = 4'b0000;
    chk("coll_pend", PENDING, 4'b0100);
    chk("coll_insvc", {3'b000, IN_SERVICE}, 4'h1);
    RETI = 1'b1; tick(1); RETI = 1'b0;
    tick(1);
    chk("coll_reserve_intr", {3'b000, INTR}, 4'h1);
    chk("coll_reserve_id", {2'b00, INT_ID}, 4'h2);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    chk("coll_cleared", PENDING, 4'b0000);
    RETI = 1'b1; tick(1); RETI = 1'b0;

    // async reset in the middle of a service with sources 3 and 1 pending
    raise_src(4'b0001);
    tick(1);
    INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    raise_src(4'b1010);
    chk("pre_rst_pend", PENDING, 4'b1010);
    chk("pre_rst_insvc", {3'b000, IN_SERVICE}, 4'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_intr", {3'b000, INTR}, 4'h0);
    chk("arst_insvc", {3'b000, IN_SERVICE}, 4'h0);
    chk("arst_pend", PENDING, 4'h0);
    chk("arst_mask", MASK, 4'h0);
    chk("arst_id", {2'b00, INT_ID}, 4'h0);
    tick(1);
    RESET_N = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Multi-source interrupt scheduler for the RAT CPU. Synchronises and edge-detects NUM_SRC external interrupt lines and latches each event as pending.
- Masks and priority-arbitrates the pending events. Presents one request at a time to the control unit, gated by the global interrupt-enable flag (I_FLAG_OUT of the I flag register).
- Supplies the winning source ID for vectoring and holds off new requests until the handler returns.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- ID_W, $clog2(NUM_SRC), width of the source ID.
- SYNC_STAGES, 2, synchroniser flops per source line (>=2).

Ports:
- clk  in  1  system clock; all state on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- INT_SRC  in  NUM_SRC  raw asynchronous interrupt lines; rising edge = event.
- I_EN  in  1  global interrupt enable, driven from I_FLAG_OUT.
- MASK_WE  in  1  write strobe for the mask register.
- MASK_IN  in  NUM_SRC  new mask value; 1 = source enabled.
- INT_ACK  in  1  one-cycle pulse from the control unit on entering its interrupt state.
- RETI  in  1  one-cycle pulse on RETID/RETIE execution (handler end).
- INTR  out  1  interrupt request to the control unit.
- INT_ID  out  ID_W  ID of the requested or in-service source.
- IN_SERVICE  out  1  high from INT_ACK until RETI.
- PENDING  out  NUM_SRC  current pending vector (debug/readback).
- MASK  out  NUM_SRC  current mask register.

Behaviour:
- Reset (async, RESET_N=0):
  - Outputs: INTR=0, INT_ID=0, IN_SERVICE=0, PENDING=0, MASK=0 (all sources disabled).
  - Internal state: synchroniser and edge-detect flops cleared; FSM in IDLE.
- Input path:
  - Each INT_SRC bit passes SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge sets PENDING[i] on the next clk.
  - Minimum latency from a raw edge to PENDING set is SYNC_STAGES+1 cycles.
- Masking:
  - A masked source still latches pending but is not eligible for arbitration.
  - MASK_WE updates MASK on the next clk. The new mask affects arbitration from the following cycle.
- Arbitration: fixed priority, lowest index wins. eligible = PENDING & MASK.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if I_EN && |eligible, latch the winner into INT_ID and go to REQ. INTR rises in the same registered cycle.
  - REQ: INTR=1, INT_ID is held stable.
    - INT_ACK=1: clear PENDING[INT_ID], set IN_SERVICE=1, drop INTR, go to SERVICE.
    - Otherwise, if I_EN=0 or MASK[INT_ID]=0: withdraw (INTR=0) and return to IDLE. PENDING stays set.
    - INT_ACK has priority over withdrawal in the same cycle.
  - SERVICE: INTR=0 and INT_ID holds the served source.
    - RETI=1: IN_SERVICE=0, go to IDLE.
    - No nesting: new events only accumulate in PENDING.
- Simultaneous events:
  - An edge on the source being cleared by INT_ACK in the same cycle leaves PENDING set (set wins over clear), so that event is not lost.
  - Multiple sources pending: after each RETI the next-lowest eligible index is served.
  - INT_ACK outside REQ and RETI outside SERVICE are ignored.
- Repeat edges: a repeat edge while already pending is merged (no counting).
- Reset mid-operation: everything returns to reset values. Any handler in progress is abandoned without RETI.

Decomposition:
- Shared package rat_intc_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} intc_state_t.
  - Localparam MAX_SRC = 8.
- Sub-module intr_edge_sync: one instance per source (generate loop). Contains the SYNC_STAGES synchroniser and rising-edge pulse, with clk/RESET_N.
- Top module holds PENDING, MASK, the priority encoder (combinational function) and the FSM.

Test Plan:
- Reset, MASK=4'b1111, I_EN=1, pulse INT_SRC[2] -> PENDING=4'b0100 after 3 cycles; INTR=1 with INT_ID=2 one cycle later; INT_ACK -> PENDING=0, IN_SERVICE=1, INTR=0; RETI -> IN_SERVICE=0, FSM IDLE.
- Edges on sources 3 and 1 in the same cycle -> INT_ID=1 served first; after RETI, INTR reasserts with INT_ID=3.
- MASK=4'b1110, edge on source 0 -> PENDING[0]=1, INTR stays 0; write MASK=4'b1111 -> INTR=1, INT_ID=0 two cycles after MASK_WE.
- In REQ with INT_ID=2, drop I_EN without ack -> INTR=0 next cycle, PENDING[2] still 1; raise I_EN -> INTR=1, INT_ID=2 again.
- Edge on source 2 lands in the INT_ACK cycle for source 2 -> PENDING[2]=1 afterwards; source 2 is served again after RETI.
- Assert RESET_N=0 mid-SERVICE with PENDING=4'b1010 -> asynchronously INTR=0, IN_SERVICE=0, PENDING=0, MASK=0.
